// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deserializer
// Function : 8N1 UART receiver with two-flop pin synchroniser, mid-bit
//            sampling, one-cycle byte strobe and separate framing-error pulse.
// Revision : 1.0
// ============================================================================
module uart_rx_deserializer #(
    parameter int CLK_PER_BIT = 100,
    parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       new_rx_data,
    output logic       framing_err,
    output logic       busy
);

    localparam logic [CTR_SIZE-1:0] c_HALF_M1 = CTR_SIZE'(CLK_PER_BIT/2 - 1);
    localparam logic [CTR_SIZE-1:0] c_FULL_M1 = CTR_SIZE'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_rx_m;
    logic                r_rx_s;
    logic [CTR_SIZE-1:0] r_ctr;
    logic [2:0]          r_bit_ctr;
    logic [7:0]          r_sh;
    logic [7:0]          r_rx_data;
    logic                r_new;
    logic                r_ferr;
    logic                r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_m    <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= ST_IDLE;
            r_ctr     <= '0;
            r_bit_ctr <= 3'd0;
            r_sh      <= 8'h00;
            r_rx_data <= 8'h00;
            r_new     <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_rx_m <= rx;
            r_rx_s <= r_rx_m;
            r_new  <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= ST_START;
                        r_ctr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                // Re-check the line half a bit in; a high level means the edge was a glitch.
                ST_START: begin
                    if (r_ctr == c_HALF_M1) begin
                        if (r_rx_s) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= ST_DATA;
                            r_ctr     <= '0;
                            r_bit_ctr <= 3'd0;
                        end
                    end else begin
                        r_ctr <= r_ctr + CTR_SIZE'(1);
                    end
                end
                ST_DATA: begin
                    if (r_ctr == c_FULL_M1) begin
                        r_sh  <= {r_rx_s, r_sh[7:1]};
                        r_ctr <= '0;
                        if (r_bit_ctr == 3'd7) begin
                            r_state   <= ST_STOP;
                            r_bit_ctr <= 3'd0;
                        end else begin
                            r_bit_ctr <= r_bit_ctr + 3'd1;
                        end
                    end else begin
                        r_ctr <= r_ctr + CTR_SIZE'(1);
                    end
                end
                // Leaving at the stop-bit midpoint leaves half a bit to catch the next start edge.
                ST_STOP: begin
                    if (r_ctr == c_FULL_M1) begin
                        r_ctr <= '0;
                        if (r_rx_s) begin
                            r_rx_data <= r_sh;
                            r_new     <= 1'b1;
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= ST_BREAK;
                        end
                    end else begin
                        r_ctr <= r_ctr + CTR_SIZE'(1);
                    end
                end
                ST_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data     = r_rx_data;
    assign new_rx_data = r_new;
    assign framing_err = r_ferr;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deserializer
// Function : Self-checking bench: directed scenarios plus random frames on a
//            16-clk/bit receiver, and baud-skew tolerance on a 100-clk/bit one.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       new_a, new_b, ferr_a, ferr_b, busy_a, busy_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_deserializer #(.CLK_PER_BIT(16)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a),
        .new_rx_data(new_a), .framing_err(ferr_a), .busy(busy_a)
    );

    uart_rx_deserializer dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b),
        .new_rx_data(new_b), .framing_err(ferr_b), .busy(busy_b)
    );

    // Event log, sampled 2 time units after each rising edge.
    logic [7:0] q_a[$];
    int         t_a[$];
    int         ferr_cnt_a = 0;
    int         excl_a = 0;
    int         cnt_b = 0;
    int         ferr_cnt_b = 0;
    logic [7:0] last_b = 8'h00;

    always @(posedge clk) begin
        #2;
        if (new_a) begin
            q_a.push_back(data_a);
            t_a.push_back(cyc);
        end
        if (ferr_a) ferr_cnt_a++;
        if (new_a && ferr_a) excl_a++;
        if (new_b) begin
            cnt_b++;
            last_b = data_b;
        end
        if (ferr_b) ferr_cnt_b++;
    end

    // Serial transmitter model: start, 8 data bits LSB first, stop; P clocks per bit.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic stop, input int p);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (sel == 0) rx_a = bits[i];
            else          rx_b = bits[i];
            if (i == 0) start_cyc = cyc + 1;
            repeat (p) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 8;
        if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data_a: got %h want 00", data_a); end
        if (new_a !== 1'b0)   begin errors++; $display("FAIL reset_new_a: got %b want 0", new_a); end
        if (ferr_a !== 1'b0)  begin errors++; $display("FAIL reset_ferr_a: got %b want 0", ferr_a); end
        if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
        if (data_b !== 8'h00) begin errors++; $display("FAIL reset_data_b: got %h want 00", data_b); end
        if (new_b !== 1'b0)   begin errors++; $display("FAIL reset_new_b: got %b want 0", new_b); end
        if (ferr_b !== 1'b0)  begin errors++; $display("FAIL reset_ferr_b: got %b want 0", ferr_b); end
        if (busy_b !== 1'b0)  begin errors++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Expected latency counts the edge that first samples the low pin as 1:
    // 2 + 16/2 + 9*16 + 1 = 155.
    task automatic test_single_frame();
        int n0, f0, lat;
        n0 = q_a.size();
        f0 = ferr_cnt_a;
        send_frame(0, 8'h30, 1'b1, 16);
        @(negedge clk);
        checks += 5;
        if (q_a.size() !== n0 + 1) begin
            errors++; $display("FAIL single_count: got %0d want %0d", q_a.size() - n0, 1);
        end else begin
            lat = t_a[n0] - start_cyc + 1;
            if (q_a[n0] !== 8'h30) begin errors++; $display("FAIL single_data: got %h want 30", q_a[n0]); end
            if (lat !== 155) begin errors++; $display("FAIL single_latency: got %0d want 155", lat); end
        end
        if (ferr_cnt_a !== f0) begin errors++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt_a - f0); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy_a); end
        if (data_a !== 8'h30) begin errors++; $display("FAIL single_hold: got %h want 30", data_a); end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = q_a.size();
        send_frame(0, 8'h31, 1'b1, 16);
        send_frame(0, 8'h41, 1'b1, 16);
        repeat (2) @(negedge clk);
        checks += 1;
        if (q_a.size() !== n0 + 2) begin
            errors++; $display("FAIL b2b_count: got %0d want 2", q_a.size() - n0);
        end else begin
            checks += 3;
            if (q_a[n0] !== 8'h31) begin errors++; $display("FAIL b2b_first: got %h want 31", q_a[n0]); end
            if (q_a[n0+1] !== 8'h41) begin errors++; $display("FAIL b2b_second: got %h want 41", q_a[n0+1]); end
            if (t_a[n0+1] - t_a[n0] !== 160) begin
                errors++; $display("FAIL b2b_spacing: got %0d want 160", t_a[n0+1] - t_a[n0]);
            end
        end
    endtask

    task automatic test_glitch();
        int n0, f0, busy_cyc;
        n0 = q_a.size();
        f0 = ferr_cnt_a;
        busy_cyc = 0;
        for (int i = 0; i < 30; i++) begin
            rx_a = (i < 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (busy_a) busy_cyc++;
        end
        checks += 4;
        if (busy_cyc < 1 || busy_cyc > 10) begin
            errors++; $display("FAIL glitch_busy: got %0d cycles want 1..10", busy_cyc);
        end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy=%b want 0", busy_a); end
        if (q_a.size() !== n0) begin errors++; $display("FAIL glitch_bytes: got %0d want 0", q_a.size() - n0); end
        if (ferr_cnt_a !== f0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt_a - f0); end
    endtask

    task automatic test_break(input logic [7:0] prev);
        int n0, f0, idle_cyc;
        n0 = q_a.size();
        f0 = ferr_cnt_a;
        idle_cyc = 0;
        send_frame(0, 8'h55, 1'b0, 16);
        for (int i = 0; i < 50 * 16; i++) begin
            @(negedge clk);
            if (!busy_a) idle_cyc++;
        end
        checks += 4;
        if (idle_cyc !== 0) begin errors++; $display("FAIL break_busy: got %0d idle cycles want 0", idle_cyc); end
        if (ferr_cnt_a - f0 !== 1) begin errors++; $display("FAIL break_ferr: got %0d want 1", ferr_cnt_a - f0); end
        if (q_a.size() !== n0) begin errors++; $display("FAIL break_bytes: got %0d want 0", q_a.size() - n0); end
        if (data_a !== prev) begin errors++; $display("FAIL break_hold: got %h want %h", data_a, prev); end
        rx_a = 1'b1;
        repeat (4) @(negedge clk);
        checks += 1;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL break_release: got busy=%b want 0", busy_a); end
        send_frame(0, 8'h30, 1'b1, 16);
        @(negedge clk);
        checks += 2;
        if (q_a.size() !== n0 + 1) begin
            errors++; $display("FAIL break_next_count: got %0d want 1", q_a.size() - n0);
        end else if (q_a[n0] !== 8'h30) begin
            errors++; $display("FAIL break_next_data: got %h want 30", q_a[n0]);
        end
        if (ferr_cnt_a - f0 !== 1) begin errors++; $display("FAIL break_total_ferr: got %0d want 1", ferr_cnt_a - f0); end
    endtask

    task automatic test_reset_midframe();
        int n0, f0;
        n0 = q_a.size();
        f0 = ferr_cnt_a;
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        rx_a = 1'b1;
        repeat (4 * 16 + 8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (data_a !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", data_a); end
        if (new_a !== 1'b0)   begin errors++; $display("FAIL midrst_new: got %b want 0", new_a); end
        if (ferr_a !== 1'b0)  begin errors++; $display("FAIL midrst_ferr: got %b want 0", ferr_a); end
        if (busy_a !== 1'b0)  begin errors++; $display("FAIL midrst_busy: got %b want 0", busy_a); end
        repeat (5 * 16) @(negedge clk);
        checks += 2;
        if (q_a.size() !== n0) begin errors++; $display("FAIL midrst_bytes: got %0d want 0", q_a.size() - n0); end
        if (ferr_cnt_a !== f0) begin errors++; $display("FAIL midrst_ferrs: got %0d want 0", ferr_cnt_a - f0); end
        send_frame(0, 8'h0A, 1'b1, 16);
        @(negedge clk);
        checks += 1;
        if (q_a.size() !== n0 + 1) begin
            errors++; $display("FAIL midrst_next_count: got %0d want 1", q_a.size() - n0);
        end else if (q_a[n0] !== 8'h0A) begin
            errors++; $display("FAIL midrst_next_data: got %h want 0a", q_a[n0]);
        end
    endtask

    // Reference model: every frame with a high stop bit yields exactly its byte, in order.
    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int n0;
        n0 = q_a.size();
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(0, b, 1'b1, 16);
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checks += 1;
        if (q_a.size() - n0 !== exp_q.size()) begin
            errors++; $display("FAIL random_count: got %0d want %0d", q_a.size() - n0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks += 1;
                if (q_a[n0+i] !== exp_q[i]) begin
                    errors++; $display("FAIL random_byte%0d: got %h want %h", i, q_a[n0+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_baud_skew();
        int periods[2];
        int n0;
        periods[0] = 97;
        periods[1] = 103;
        for (int k = 0; k < 2; k++) begin
            n0 = cnt_b;
            send_frame(1, 8'hA5, 1'b1, periods[k]);
            repeat (2 * periods[k]) @(negedge clk);
            checks += 2;
            if (cnt_b - n0 !== 1) begin
                errors++; $display("FAIL skew%0d_count: got %0d want 1", periods[k], cnt_b - n0);
            end
            if (last_b !== 8'hA5) begin
                errors++; $display("FAIL skew%0d_data: got %h want a5", periods[k], last_b);
            end
        end
        checks += 1;
        if (ferr_cnt_b !== 0) begin errors++; $display("FAIL skew_ferr: got %0d want 0", ferr_cnt_b); end
    endtask

    task automatic test_exclusive();
        checks += 1;
        if (excl_a !== 0) begin errors++; $display("FAIL strobe_exclusive: got %0d overlaps want 0", excl_a); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_break(8'h41);
        test_reset_midframe();
        test_random();
        test_baud_skew();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
